// File: rtl/stream_fifo_pkt.sv
// stream_fifo_pkt: AXI-Stream FIFO with configurable data width and depth.
// It carries TLAST with each word and reports occupancy plus an almost-full flag.
//
// Ports:
//   clk, rst        - rising-edge clock, asynchronous active-high reset
//   m_t*            - upstream (write) AXI-Stream: tdata, tlast, tvalid in / tready out
//   s_t*            - downstream (read) AXI-Stream: tdata, tlast, tvalid out / tready in
//   count           - stored entries, 0..DEPTH
//   m_afull         - count >= AFULL_THRESH
//   pkt_oversize    - sticky oversize-packet flag (store-and-forward build only)
//
// Optional feature: define STREAM_FIFO_PKT_STORE_FWD_EN for store-and-forward packet
// mode. In that mode a word is only offered downstream once a complete packet
// (TLAST) is stored. A packet that fills the FIFO without a TLAST falls back to
// cut-through.
//
// All outputs are registered. Next-state pointers are computed combinationally
// and the head-of-queue word is preloaded into r_s_data. This gives
// first-word-fall-through with one cycle of latency and no combinational
// s_tready -> m_tready path.

module stream_fifo_pkt #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned AFULL_THRESH = DEPTH - 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   m_tdata,
    input  logic                    m_tlast,
    input  logic                    m_tvalid,
    output logic                    m_tready,
    output logic [DATA_WIDTH-1:0]   s_tdata,
    output logic                    s_tlast,
    output logic                    s_tvalid,
    input  logic                    s_tready,
    output logic [$clog2(DEPTH):0]  count,
`ifdef STREAM_FIFO_PKT_STORE_FWD_EN
    output logic                    pkt_oversize,
`endif
    output logic                    m_afull
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned EW = DATA_WIDTH + 1;
    localparam logic [PW-1:0] C_AFULL = PW'(AFULL_THRESH);

    // Storage: {tlast, tdata} per entry, not reset
    logic [EW-1:0] r_mem [DEPTH];

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_count;
    logic          r_m_tready;
    logic          r_s_tvalid;
    logic [EW-1:0] r_s_data;
    logic          r_afull;

    logic          w_push;
    logic          w_pop;
    logic [AW-1:0] w_wr_idx;
    logic [PW-1:0] w_wr_ptr_n;
    logic [PW-1:0] w_rd_ptr_n;
    logic [AW-1:0] w_rd_idx_n;
    logic [PW-1:0] w_count_n;
    logic          w_empty_n;
    logic          w_full_n;
    logic [EW-1:0] w_head_n;
    logic          w_s_tvalid_n;

`ifdef STREAM_FIFO_PKT_STORE_FWD_EN
    logic [PW-1:0] r_pkt_cnt;
    logic          r_cut;
    logic          r_oversize;
    logic [PW-1:0] w_pkt_cnt_n;
    logic          w_cut_n;
    logic          w_stuck_n;
`endif

    // Next-state pointers, occupancy and head-of-queue word
    always_comb begin
        w_push       = m_tvalid && r_m_tready;
        w_pop        = r_s_tvalid && s_tready;
        w_wr_idx     = r_wr_ptr[AW-1:0];
        w_wr_ptr_n   = r_wr_ptr + PW'(w_push);
        w_rd_ptr_n   = r_rd_ptr + PW'(w_pop);
        w_rd_idx_n   = w_rd_ptr_n[AW-1:0];
        w_count_n    = r_count;
        w_empty_n    = 1'b0;
        w_full_n     = 1'b0;
        w_head_n     = r_mem[w_rd_idx_n];
        w_s_tvalid_n = 1'b0;

        case ({w_push, w_pop})
            2'b10:   w_count_n = r_count + PW'(1);
            2'b01:   w_count_n = r_count - PW'(1);
            default: w_count_n = r_count;
        endcase

        w_empty_n = (w_wr_ptr_n == w_rd_ptr_n);
        w_full_n  = (w_wr_ptr_n[AW-1:0] == w_rd_ptr_n[AW-1:0]) &&
                    (w_wr_ptr_n[AW] != w_rd_ptr_n[AW]);

        // The word written this edge lands at the new head only when the queue was
        // (or becomes) empty. Take it straight from the input.
        if (w_push && (w_wr_idx == w_rd_idx_n)) begin
            w_head_n = {m_tlast, m_tdata};
        end

`ifdef STREAM_FIFO_PKT_STORE_FWD_EN
        w_pkt_cnt_n = r_pkt_cnt;
        case ({w_push && m_tlast, w_pop && r_s_data[EW-1]})
            2'b10:   w_pkt_cnt_n = r_pkt_cnt + PW'(1);
            2'b01:   w_pkt_cnt_n = r_pkt_cnt - PW'(1);
            default: w_pkt_cnt_n = r_pkt_cnt;
        endcase
        // Full with no complete packet stored would deadlock. Release the packet
        // cut-through until its TLAST leaves.
        w_stuck_n    = w_full_n && (w_pkt_cnt_n == '0);
        w_cut_n      = (r_cut && !(w_pop && r_s_data[EW-1])) || w_stuck_n;
        w_s_tvalid_n = !w_empty_n && ((w_pkt_cnt_n != '0) || w_full_n || w_cut_n);
`else
        w_s_tvalid_n = !w_empty_n;
`endif
    end

    // Pointer, occupancy and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_m_tready <= 1'b1;
            r_s_tvalid <= 1'b0;
            r_s_data   <= '0;
            r_afull    <= 1'b0;
        end else begin
            r_wr_ptr   <= w_wr_ptr_n;
            r_rd_ptr   <= w_rd_ptr_n;
            r_count    <= w_count_n;
            r_m_tready <= !w_full_n;
            r_s_tvalid <= w_s_tvalid_n;
            r_s_data   <= w_head_n;
            r_afull    <= (w_count_n >= C_AFULL);
        end
    end

`ifdef STREAM_FIFO_PKT_STORE_FWD_EN
    // Packet accounting for store-and-forward
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pkt_cnt  <= '0;
            r_cut      <= 1'b0;
            r_oversize <= 1'b0;
        end else begin
            r_pkt_cnt  <= w_pkt_cnt_n;
            r_cut      <= w_cut_n;
            r_oversize <= r_oversize || w_stuck_n;
        end
    end

    assign pkt_oversize = r_oversize;
`endif

    // Storage write port
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[w_wr_idx] <= {m_tlast, m_tdata};
        end
    end

    assign m_tready = r_m_tready;
    assign s_tvalid = r_s_tvalid;
    assign s_tdata  = r_s_data[DATA_WIDTH-1:0];
    assign s_tlast  = r_s_data[EW-1];
    assign count    = r_count;
    assign m_afull  = r_afull;

endmodule

// File: doc/stream_fifo_pkt.md
Name: stream_fifo_pkt

Overview:
- Parametrised successor to the single-width stream FIFO: an AXI-Stream FIFO with configurable data width and depth.
- Carries TLAST alongside the data.
- Exposes an occupancy count and an almost-full flag.
- Optionally runs in store-and-forward packet mode.
- Sits between NoC router ports and the AXI bridges, where both queue implementations sit today.

Parameters:
DATA_WIDTH, 32, TDATA width in bits (>=1)
DEPTH, 16, number of entries; power of two, >=2
AFULL_THRESH, DEPTH-2, m_afull asserts when count >= AFULL_THRESH (1..DEPTH)

Ports:
clk  input  1  clock, all logic rising-edge
rst  input  1  asynchronous active-high reset
m_tdata  input  DATA_WIDTH  upstream data
m_tlast  input  1  upstream end-of-packet
m_tvalid  input  1  upstream valid
m_tready  output  1  FIFO can accept
s_tdata  output  DATA_WIDTH  downstream data
s_tlast  output  1  downstream end-of-packet
s_tvalid  output  1  downstream valid
s_tready  input  1  downstream ready
count  output  $clog2(DEPTH)+1  stored entries, 0..DEPTH
m_afull  output  1  count >= AFULL_THRESH

Behaviour:
- Interface: one clock, clk; asynchronous active-high reset, rst.
- Reset (async assert, sync-safe deassert by the system):
  - wr_ptr = rd_ptr = 0, count = 0.
  - m_tready = 1 (after rst drops), s_tvalid = 0, s_tdata = 0, s_tlast = 0, m_afull = 0.
  - Memory contents are not reset.
- Storage: DEPTH x (DATA_WIDTH+1) array; pointers are $clog2(DEPTH)+1 bits wide with an extra wrap bit.
  - empty = (wr_ptr == rd_ptr).
  - full = index bits equal and wrap bits differ.
- Handshakes:
  - Push on m_tvalid && m_tready. Pop on s_tvalid && s_tready.
  - m_tready = !full, from registered pointers only; no combinational path from s_tready.
  - s_tvalid is never dropped while waiting for s_tready.
  - s_tdata and s_tlast stay stable until the pop.
- Latency: word pushed at edge N is visible on s_tdata with s_tvalid=1 after edge N (first-word-fall-through, 1 cycle). No bypass path when empty.
- Count:
  - +1 on push only, -1 on pop only.
  - Unchanged on simultaneous push and pop.
  - m_afull is derived from count in the same cycle.
- Full with s_tready=1: the pop occurs and m_tready stays 0 that cycle; the push is accepted in the next cycle.
- Empty with m_tvalid=1: the push occurs; no pop, since s_tvalid=0.
- Pointer wrap: the index wraps modulo DEPTH and the wrap bit toggles. Ordering is preserved across the wrap.
- Reset mid-transfer: all stored words are discarded; the first word after reset is the first word pushed after reset.
- Overflow/underflow are impossible by construction. Asserting m_tvalid while m_tready=0 has no effect; the data is held upstream.

Optional Feature:
- Macro: STREAM_FIFO_PKT_STORE_FWD_EN.
- Defined (store-and-forward mode):
  - Internal pkt_cnt (width as count) increments on a push with m_tlast=1 and decrements on a pop with s_tlast=1.
  - pkt_cnt is unchanged when both happen in the same cycle.
  - s_tvalid = !empty && (pkt_cnt != 0 || full).
  - Oversize fallback: if full with pkt_cnt==0, the FIFO switches to cut-through for that packet to avoid deadlock, and sets a sticky output pkt_oversize (1 bit, reset 0, cleared only by rst).
  - The pkt_oversize port exists only when the macro is defined.
- Undefined: pure cut-through as described in Behaviour; no pkt_cnt and no pkt_oversize.

Test Plan:
- Reset, then push 0xA5A5_0001 with s_tready=0 -> after next edge s_tvalid=1, s_tdata=0xA5A5_0001, count=1; no pop while s_tready=0.
- DEPTH=16, push 16 words 0..15 with s_tready=0 -> m_tready=0 after 16th, count=16, m_afull=1 from count=14; then s_tready=1 drains 0..15 in order, count returns 0, s_tvalid=0.
- Full FIFO, m_tvalid=1 and s_tready=1 in the same cycle -> pop only, count 16->15; next cycle push and pop both occur, count stays 15.
- Stream 40 words with random valid/ready (seed fixed) -> output sequence identical to input, ptr wrap exercised twice, count never exceeds 16.
- Assert rst for 1 cycle while count=7 -> count=0, s_tvalid=0 immediately (async); next pushed 0x1234 is the first word out.
- With STREAM_FIFO_PKT_STORE_FWD_EN:
  - Push a 3-word packet (tlast on word 3) with s_tready=1 -> s_tvalid stays 0 until the cycle after word 3 is pushed.
  - Push a 20-word packet -> cut-through fallback when full, pkt_oversize=1 and sticky.
